// File: rtl/imm_gen_pipe_if.sv
// Handshake bundle for imm_gen_pipe: instruction input side and decoded-immediate output side.
interface imm_gen_pipe_if #(
  parameter int XLEN  = 64,
  parameter int TAG_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_instr;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_imm;
  logic [2:0]       out_fmt;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, in_instr, in_tag, out_ready,
    input  in_ready, out_valid, out_imm, out_fmt, out_tag
  );

  modport slave (
    input  in_valid, in_instr, in_tag, out_ready,
    output in_ready, out_valid, out_imm, out_fmt, out_tag
  );
endinterface

// File: rtl/imm_gen_pipe.sv
// Pipelined RV32I/RV64I immediate generator with a registered valid/ready stage
// backed by a skid register so in_ready never depends combinationally on out_ready.
module imm_gen_pipe #(
  parameter int XLEN        = 64,
  parameter int TAG_W       = 8,
  parameter int HALF_OFFSET = 0
) (
  input logic          clk,
  input logic          reset,
  imm_gen_pipe_if.slave bus
);

  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5
  } fmt_e;

  typedef enum logic [1:0] {
    EMPTY,
    ONE,
    FULL
  } state_e;

  state_e           state;
  logic [XLEN-1:0]  m_imm, k_imm;
  fmt_e             m_fmt, k_fmt;
  logic [TAG_W-1:0] m_tag, k_tag;

  logic [31:0]      ins;
  logic [63:0]      dec_wide;
  logic [XLEN-1:0]  dec_imm;
  fmt_e             dec_fmt;
  logic             in_xfer, out_xfer;

  assign ins = bus.in_instr;

  // Opcodes all end in 2'b11, so matching the full 7 bits also enforces that check.
  always_comb begin
    dec_wide = '0;
    dec_fmt  = FMT_NONE;
    case (ins[6:0])
      7'b0000011, 7'b0010011, 7'b0011011, 7'b1100111: begin
        dec_wide = {{52{ins[31]}}, ins[31:20]};
        dec_fmt  = FMT_I;
      end
      7'b0100011: begin
        dec_wide = {{52{ins[31]}}, ins[31:25], ins[11:7]};
        dec_fmt  = FMT_S;
      end
      7'b1100011: begin
        if (HALF_OFFSET != 0)
          dec_wide = {{52{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8]};
        else
          dec_wide = {{51{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
        dec_fmt = FMT_B;
      end
      7'b0110111, 7'b0010111: begin
        dec_wide = {{32{ins[31]}}, ins[31:12], 12'b0};
        dec_fmt  = FMT_U;
      end
      7'b1101111: begin
        if (HALF_OFFSET != 0)
          dec_wide = {{44{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21]};
        else
          dec_wide = {{43{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
        dec_fmt = FMT_J;
      end
      default: begin
        dec_wide = '0;
        dec_fmt  = FMT_NONE;
      end
    endcase
  end

  assign dec_imm  = dec_wide[XLEN-1:0];
  assign in_xfer  = bus.in_valid & bus.in_ready;
  assign out_xfer = bus.out_valid & bus.out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= EMPTY;
      m_imm <= '0;
      m_fmt <= FMT_NONE;
      m_tag <= '0;
      k_imm <= '0;
      k_fmt <= FMT_NONE;
      k_tag <= '0;
    end else begin
      case (state)
        EMPTY: begin
          if (in_xfer) begin
            m_imm <= dec_imm;
            m_fmt <= dec_fmt;
            m_tag <= bus.in_tag;
            state <= ONE;
          end
        end
        ONE: begin
          if (in_xfer && out_xfer) begin
            m_imm <= dec_imm;
            m_fmt <= dec_fmt;
            m_tag <= bus.in_tag;
          end else if (in_xfer) begin
            // M is stalled: park the new entry in the skid register.
            k_imm <= dec_imm;
            k_fmt <= dec_fmt;
            k_tag <= bus.in_tag;
            state <= FULL;
          end else if (out_xfer) begin
            state <= EMPTY;
          end
        end
        FULL: begin
          if (out_xfer) begin
            m_imm <= k_imm;
            m_fmt <= k_fmt;
            m_tag <= k_tag;
            state <= ONE;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

  assign bus.in_ready  = (state != FULL);
  assign bus.out_valid = (state != EMPTY);
  assign bus.out_imm   = m_imm;
  assign bus.out_fmt   = m_fmt;
  assign bus.out_tag   = m_tag;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Scoreboard bench for imm_gen_pipe: a 64-bit byte-offset instance and a 32-bit
// halfword-offset instance driven in lockstep.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [31:0] in_instr;
  logic [7:0]  in_tag;
  logic        out_ready;

  always #5 clk = ~clk;

  imm_gen_pipe_if #(.XLEN(64), .TAG_W(8)) b64 ();
  imm_gen_pipe_if #(.XLEN(32), .TAG_W(8)) b32 ();

  assign b64.in_valid  = in_valid;
  assign b64.in_instr  = in_instr;
  assign b64.in_tag    = in_tag;
  assign b64.out_ready = out_ready;
  assign b32.in_valid  = in_valid;
  assign b32.in_instr  = in_instr;
  assign b32.in_tag    = in_tag;
  assign b32.out_ready = out_ready;

  imm_gen_pipe #(.XLEN(64), .TAG_W(8), .HALF_OFFSET(0)) dut64 (
    .clk(clk), .reset(reset), .bus(b64.slave)
  );
  imm_gen_pipe #(.XLEN(32), .TAG_W(8), .HALF_OFFSET(1)) dut32 (
    .clk(clk), .reset(reset), .bus(b32.slave)
  );

  int total = 0;
  int bad   = 0;
  int out_cnt = 0;

  typedef struct {
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic [7:0]  tag;
  } exp_t;

  exp_t q64[$];
  exp_t q32[$];

  function automatic logic [2:0] model_fmt(logic [31:0] i);
    case (i[6:0])
      7'h03, 7'h13, 7'h1B, 7'h67: return 3'd1;
      7'h23:                      return 3'd2;
      7'h63:                      return 3'd3;
      7'h37, 7'h17:               return 3'd4;
      7'h6F:                      return 3'd5;
      default:                    return 3'd0;
    endcase
  endfunction

  function automatic logic [63:0] model_imm(logic [31:0] i, int xlen, int half);
    logic signed [63:0] s, hi, r;
    s = {{32{i[31]}}, i};
    r = '0;
    case (i[6:0])
      7'h03, 7'h13, 7'h1B, 7'h67: r = s >>> 20;
      7'h23: begin
        hi = s >>> 25;
        r  = (hi << 5) | 64'(i[11:7]);
      end
      7'h63: begin
        hi = s >>> 31;
        r  = (hi << 12) | (64'(i[7]) << 11) | (64'(i[30:25]) << 5) | (64'(i[11:8]) << 1);
        if (half != 0) r = r >>> 1;
      end
      7'h37, 7'h17: r = s & ~64'hFFF;
      7'h6F: begin
        hi = s >>> 31;
        r  = (hi << 20) | (64'(i[19:12]) << 12) | (64'(i[20]) << 11) | (64'(i[30:21]) << 1);
        if (half != 0) r = r >>> 1;
      end
      default: r = '0;
    endcase
    if (xlen == 32) r[63:32] = '0;
    return r;
  endfunction

  // Scoreboard: pops and compares on output transfers, pushes on input transfers.
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      q64.delete();
      q32.delete();
    end else begin
      if (b64.out_valid && out_ready) begin
        out_cnt++;
        total++;
        if (q64.size() == 0) begin
          bad++;
          $display("FAIL sb64_unexpected: got tag=%h with empty queue", b64.out_tag);
        end else begin
          e = q64.pop_front();
          if ({b64.out_imm, b64.out_fmt, b64.out_tag} !== {e.imm, e.fmt, e.tag}) begin
            bad++;
            $display("FAIL sb64: got imm=%h fmt=%0d tag=%h want imm=%h fmt=%0d tag=%h",
                     b64.out_imm, b64.out_fmt, b64.out_tag, e.imm, e.fmt, e.tag);
          end
        end
      end
      if (b32.out_valid && out_ready) begin
        total++;
        if (q32.size() == 0) begin
          bad++;
          $display("FAIL sb32_unexpected: got tag=%h with empty queue", b32.out_tag);
        end else begin
          e = q32.pop_front();
          if ({b32.out_imm, b32.out_fmt, b32.out_tag} !== {e.imm[31:0], e.fmt, e.tag}) begin
            bad++;
            $display("FAIL sb32: got imm=%h fmt=%0d tag=%h want imm=%h fmt=%0d tag=%h",
                     b32.out_imm, b32.out_fmt, b32.out_tag, e.imm[31:0], e.fmt, e.tag);
          end
        end
      end
      if (in_valid && b64.in_ready)
        q64.push_back('{model_imm(in_instr, 64, 0), model_fmt(in_instr), in_tag});
      if (in_valid && b32.in_ready)
        q32.push_back('{model_imm(in_instr, 32, 1), model_fmt(in_instr), in_tag});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; in_instr = '0; in_tag = '0; out_ready = 1'b0;
    #1;
    total++;
    if ({b64.out_valid, b64.in_ready, b64.out_imm, b64.out_fmt, b64.out_tag} !==
        {1'b0, 1'b1, 64'd0, 3'd0, 8'd0}) begin
      bad++;
      $display("FAIL reset64: got v=%b r=%b imm=%h fmt=%0d tag=%h want v=0 r=1 zeros",
               b64.out_valid, b64.in_ready, b64.out_imm, b64.out_fmt, b64.out_tag);
    end
    total++;
    if ({b32.out_valid, b32.in_ready, b32.out_imm, b32.out_fmt, b32.out_tag} !==
        {1'b0, 1'b1, 32'd0, 3'd0, 8'd0}) begin
      bad++;
      $display("FAIL reset32: got v=%b r=%b imm=%h want v=0 r=1 zeros",
               b32.out_valid, b32.in_ready, b32.out_imm);
    end
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_formats();
    logic [31:0] v_ins[8] = '{32'hFF813083, 32'h00513823, 32'hFE000EE3, 32'h800000B7,
                              32'h00000033, 32'hFFDFF06F, 32'h00001097, 32'hFFF00093};
    logic [63:0] v_e64[8] = '{64'hFFFFFFFFFFFFFFF8, 64'h10, 64'hFFFFFFFFFFFFFFFC,
                              64'hFFFFFFFF80000000, 64'h0, 64'hFFFFFFFFFFFFFFFC,
                              64'h1000, 64'hFFFFFFFFFFFFFFFF};
    logic [31:0] v_e32[8] = '{32'hFFFFFFF8, 32'h10, 32'hFFFFFFFE, 32'h80000000,
                              32'h0, 32'hFFFFFFFE, 32'h1000, 32'hFFFFFFFF};
    logic [2:0]  v_fmt[8] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd0, 3'd5, 3'd4, 3'd1};
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      in_valid = 1'b1;
      in_instr = v_ins[k];
      in_tag   = 8'h10 + 8'(k);
      step();
      total++;
      if ({b64.out_valid, b64.out_imm, b64.out_fmt, b64.out_tag} !==
          {1'b1, v_e64[k], v_fmt[k], 8'h10 + 8'(k)}) begin
        bad++;
        $display("FAIL fmt64[%0d]: got v=%b imm=%h fmt=%0d tag=%h want v=1 imm=%h fmt=%0d",
                 k, b64.out_valid, b64.out_imm, b64.out_fmt, b64.out_tag, v_e64[k], v_fmt[k]);
      end
      total++;
      if ({b32.out_valid, b32.out_imm, b32.out_fmt} !== {1'b1, v_e32[k], v_fmt[k]}) begin
        bad++;
        $display("FAIL fmt32[%0d]: got v=%b imm=%h fmt=%0d want v=1 imm=%h fmt=%0d",
                 k, b32.out_valid, b32.out_imm, b32.out_fmt, v_e32[k], v_fmt[k]);
      end
    end
    in_valid = 1'b0;
    step();
    total++;
    if (b64.out_valid !== 1'b0) begin
      bad++;
      $display("FAIL fmt_drain: got out_valid=%b want 0", b64.out_valid);
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'hFF813083; in_tag = 8'd1;
    step();
    total++;
    if ({b64.in_ready, b64.out_valid, b64.out_tag} !== {1'b1, 1'b1, 8'd1}) begin
      bad++;
      $display("FAIL bp_first: got r=%b v=%b tag=%h want r=1 v=1 tag=01",
               b64.in_ready, b64.out_valid, b64.out_tag);
    end
    in_instr = 32'h00513823; in_tag = 8'd2;
    step();
    total++;
    if (b64.in_ready !== 1'b0) begin
      bad++;
      $display("FAIL bp_full: got in_ready=%b want 0", b64.in_ready);
    end
    in_instr = 32'hFE000EE3; in_tag = 8'd3;
    for (int c = 0; c < 2; c++) begin
      step();
      total++;
      if ({b64.in_ready, b64.out_valid, b64.out_tag, b64.out_imm, b64.out_fmt} !==
          {1'b0, 1'b1, 8'd1, 64'hFFFFFFFFFFFFFFF8, 3'd1}) begin
        bad++;
        $display("FAIL bp_stable[%0d]: got r=%b v=%b tag=%h imm=%h fmt=%0d want r=0 v=1 tag=01",
                 c, b64.in_ready, b64.out_valid, b64.out_tag, b64.out_imm, b64.out_fmt);
      end
    end
    out_ready = 1'b1;
    step();
    total++;
    if ({b64.out_valid, b64.out_tag, b64.out_imm} !== {1'b1, 8'd2, 64'h10}) begin
      bad++;
      $display("FAIL bp_tag2: got v=%b tag=%h imm=%h want v=1 tag=02 imm=10",
               b64.out_valid, b64.out_tag, b64.out_imm);
    end
    step();
    total++;
    if ({b64.out_valid, b64.out_tag, b32.out_imm} !== {1'b1, 8'd3, 32'hFFFFFFFE}) begin
      bad++;
      $display("FAIL bp_tag3: got v=%b tag=%h imm32=%h want v=1 tag=03 imm32=fffffffe",
               b64.out_valid, b64.out_tag, b32.out_imm);
    end
    in_valid = 1'b0;
    step();
    total++;
    if (b64.out_valid !== 1'b0) begin
      bad++;
      $display("FAIL bp_drain: got out_valid=%b want 0", b64.out_valid);
    end
  endtask

  task automatic test_throughput();
    int start;
    logic [31:0] r;
    start = out_cnt;
    out_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      r = $urandom();
      in_valid = 1'b1;
      in_instr = {r[31:7], 7'h13};
      in_tag   = 8'h40 + 8'(c);
      step();
    end
    in_valid = 1'b0;
    step();
    total++;
    if (out_cnt - start != 20) begin
      bad++;
      $display("FAIL throughput: got %0d outputs want 20", out_cnt - start);
    end
  endtask

  task automatic test_back_to_back();
    logic [6:0]  ops[12] = '{7'h03, 7'h13, 7'h1B, 7'h67, 7'h23, 7'h63,
                             7'h37, 7'h17, 7'h6F, 7'h33, 7'h0F, 7'h00};
    logic [31:0] r;
    int          n;
    for (int c = 0; c < 300; c++) begin
      r = $urandom();
      n = $urandom_range(0, 11);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      in_instr  = (n == 11) ? r : {r[31:7], ops[n]};
      in_tag    = 8'(c);
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while (b64.out_valid && n < 10) begin
      step();
      n++;
    end
    step();
    total++;
    if (b64.out_valid !== 1'b0 || q64.size() != 0 || q32.size() != 0) begin
      bad++;
      $display("FAIL b2b_drain: got out_valid=%b q64=%0d q32=%0d want 0 0 0",
               b64.out_valid, q64.size(), q32.size());
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = 32'h800000B7; in_tag = 8'hA1;
    step();
    in_tag = 8'hA2;
    step();
    in_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    total++;
    if ({b64.out_valid, b64.in_ready, b64.out_imm, b64.out_tag, b32.out_valid, b32.in_ready} !==
        {1'b0, 1'b1, 64'd0, 8'd0, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL reset_mid: got v=%b r=%b imm=%h tag=%h v32=%b r32=%b want v=0 r=1 zeros",
               b64.out_valid, b64.in_ready, b64.out_imm, b64.out_tag,
               b32.out_valid, b32.in_ready);
    end
    step();
    reset     = 1'b0;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_instr  = 32'hFFDFF06F;
    in_tag    = 8'h5A;
    step();
    total++;
    if ({b64.out_valid, b64.out_tag, b64.out_fmt} !== {1'b1, 8'h5A, 3'd5}) begin
      bad++;
      $display("FAIL reset_first: got v=%b tag=%h fmt=%0d want v=1 tag=5a fmt=5",
               b64.out_valid, b64.out_tag, b64.out_fmt);
    end
    in_valid = 1'b0;
    step();
    total++;
    if (b64.out_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_stale: got out_valid=%b want 0", b64.out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_formats();
    test_backpressure();
    test_throughput();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
- Parametrised, pipelined successor to the combinational immediate generator in the decode path.
- Decodes all RV32I/RV64I immediate formats (I, S, B, U, J), not just ld/sd/beq.
- Sign-extends each immediate to XLEN bits.
- Presents the result through a registered valid/ready stage with a 2-entry skid buffer, so decode can be back-pressured without losing instructions or dropping throughput.

Parameters:
- XLEN, 64, output immediate width; legal values 32 or 64.
- TAG_W, 8, width of the sideband tag (PC index / ROB id) carried alongside each instruction.
- HALF_OFFSET, 0, 0 = B/J immediates are byte offsets with bit0 = 0; 1 = legacy halfword-scaled form (offset >> 1, sign-extended) for the existing branch adder.

Ports:
- clk, input, 1, clock; all state updates on the rising edge.
- reset, input, 1, asynchronous, active-high; clears all state immediately.
- in_valid, input, 1, in_instr / in_tag are valid this cycle.
- in_ready, output, 1, block can accept an instruction this cycle.
- in_instr, input, 32, raw instruction word.
- in_tag, input, TAG_W, sideband, passed through unchanged.
- out_valid, output, 1, out_* fields hold a decoded entry.
- out_ready, input, 1, consumer accepts the entry this cycle.
- out_imm, output, XLEN, sign-extended immediate.
- out_fmt, output, 3, format code: 0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J.
- out_tag, output, TAG_W, tag of the presented entry.

Behaviour:
- Opcode decode uses in_instr[6:0]; bits [1:0] must be 2'b11, otherwise NONE.
- I format: LOAD 0000011, OP-IMM 0010011, OP-IMM-32 0011011, JALR 1100111.
  - imm = sext(instr[31:20]).
  - Shift-immediates are not specially masked.
- S format: STORE 0100011; imm = sext({instr[31:25], instr[11:7]}).
- B format: BRANCH 1100011.
  - imm = sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}).
  - HALF_OFFSET = 1 drops the trailing 0 (sign still from instr[31]).
- U format: LUI 0110111, AUIPC 0010111; imm = sext({instr[31:12], 12'b0}). For XLEN = 64, bits 63:32 copy instr[31].
- J format: JAL 1101111.
  - imm = sext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}).
  - HALF_OFFSET applies as for B.
- Any other opcode: imm = 0, fmt = NONE. The entry is still passed through; it is not an error.
- Storage: main register M (drives out_*) and skid register K, each with its own valid bit.
- Latency: 1 cycle. An instruction accepted at edge N is visible on out_* after edge N when M was empty or draining.
- Handshakes:
  - in_ready = ~K.valid, a registered-state function with no combinational path from out_ready.
  - Input transfer: in_valid & in_ready.
  - Output transfer: out_valid & out_ready.
  - out_valid = M.valid.
  - out_* are stable while out_valid & ~out_ready.
- State transitions, per edge:
  - EMPTY (M = 0, K = 0): input transfer loads M.
  - ONE (M = 1, K = 0):
    - input and output transfer → M loads new entry;
    - input only → new entry goes to K (FULL);
    - output only → EMPTY.
  - FULL (M = 1, K = 1): in_ready = 0. Output transfer → M takes K, K clears (ONE).
- Ordering: strictly FIFO; no entry is dropped or duplicated.
- Sustained throughput is 1 per cycle when out_ready is held high.
- Reset:
  - Asynchronously clears M.valid, K.valid, out_imm, out_fmt, out_tag to 0; in_ready reads 1.
  - Reset mid-operation discards both entries.
  - The first input transfer is possible on the first edge after reset deasserts.
- Data registers load only on transfer; no X propagation when in_valid = 0.

Test Plan:
- ld x1,-8(x2), in_instr = 0xFF813083, out_ready = 1 → one cycle later out_valid = 1, out_imm = 0xFFFFFFFFFFFFFFF8, out_fmt = 1, out_tag echoed.
- sd x5,16(x2) = 0x00513823 → out_imm = 0x0000000000000010, fmt = 2.
- beq x0,x0,-4 = 0xFE000EE3 → with HALF_OFFSET = 0, imm = 0xFFFFFFFFFFFFFFFC, fmt = 3; with HALF_OFFSET = 1, imm = 0xFFFFFFFFFFFFFFFE.
- lui x1,0x80000 = 0x800000B7 → XLEN = 64 gives imm = 0xFFFFFFFF80000000, fmt = 4; XLEN = 32 gives 0x80000000. Also add = 0x00000033 → imm = 0, fmt = 0.
- Back-pressure: tags 1, 2, 3 offered back-to-back with out_ready = 0 for 3 cycles.
  - in_ready drops after 2 accepts; out_* stay stable.
  - Raising out_ready yields tags 1, 2, 3 in order, each once.
  - With out_ready held at 1, throughput is 1 per cycle.
- Reset with M and K both full → out_valid = 0 and in_ready = 1 without a clock edge; no stale entry appears after release.
